// File: rtl/triag_surf_sched.sv
// triag_surf_sched
// Shares one pipelined triangle-surface unit between N requesters.
// Each requester offers an operand pair over a valid/ready handshake.
// A round-robin arbiter issues at most one operation per cycle to the unit.
// A tag pipeline that matches the unit latency routes each returning result
// back to its owner, where it is held until the owner consumes it.
//
// Ports:
//   clk, rst_n                 clock; synchronous active-low reset
//   req_valid[N], req_a/req_b  operand pairs, 16 bits per requester
//   req_ready[N]               one-hot grant (or zero)
//   res_valid[N], res_surf     held results, 32 bits per requester
//   res_ready[N]               result consume strobe
//   calc_en, calc_a, calc_b    issue to the surface unit
//   calc_valid, calc_surf      return from the surface unit
//   busy                       any requester or tag still active
//   sync_err                   sticky: calc_valid disagreed with the tag pipe
module triag_surf_sched #(
  parameter int N   = 4,
  parameter int LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [16*N-1:0] req_a,
  input  logic [16*N-1:0] req_b,
  output logic [N-1:0]    req_ready,
  output logic [N-1:0]    res_valid,
  output logic [32*N-1:0] res_surf,
  input  logic [N-1:0]    res_ready,
  output logic            calc_en,
  output logic [15:0]     calc_a,
  output logic [15:0]     calc_b,
  input  logic            calc_valid,
  input  logic [31:0]     calc_surf,
  output logic            busy,
  output logic            sync_err
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int IW  = IDW + 1;
  localparam int MW  = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, INFLIGHT, DONE} state_t;

  logic [N-1:0]   eligible;
  logic [N-1:0]   idle_vec;
  logic [N-1:0]   retire_hit;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           grant_any;
  logic [IW-1:0]  sum;
  logic [IDW-1:0] idx;

  logic [IDW-1:0] rr_ptr_reg;
  logic           calc_en_reg;
  logic [15:0]    calc_a_reg;
  logic [15:0]    calc_b_reg;
  logic [IDW-1:0] calc_id_reg;

  logic [LAT-1:0] tag_v_reg;
  logic [IDW-1:0] tag_id_reg [LAT];
  logic           last_v;
  logic [IDW-1:0] last_id;

  logic [MW-1:0]  mask_cnt_reg;
  logic           sync_err_reg;

  logic [15:0]    a_arr [N];
  logic [15:0]    b_arr [N];

  assign last_v  = tag_v_reg[LAT-1];
  assign last_id = tag_id_reg[LAT-1];

  // Per-requester state machine and held result register.
  for (genvar gi = 0; gi < N; gi++) begin : g_req
    state_t      state_reg;
    state_t      state_next;
    logic [31:0] surf_reg;

    assign a_arr[gi] = req_a[16*gi +: 16];
    assign b_arr[gi] = req_b[16*gi +: 16];

    // Gated by rst_n so no handshake can complete while reset is applied.
    assign eligible[gi]   = rst_n && req_valid[gi] && (state_reg == IDLE);
    assign idle_vec[gi]   = (state_reg == IDLE);
    assign retire_hit[gi] = last_v && (last_id == IDW'(gi));
    assign res_valid[gi]  = (state_reg == DONE);
    assign res_surf[32*gi +: 32] = surf_reg;

    always_comb begin
      state_next = state_reg;
      case (state_reg)
        IDLE:     if (grant[gi])      state_next = INFLIGHT;
        INFLIGHT: if (retire_hit[gi]) state_next = DONE;
        DONE:     if (res_ready[gi])  state_next = IDLE;
        default:                      state_next = IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_reg <= IDLE;
        surf_reg  <= '0;
      end else begin
        state_reg <= state_next;
        if (state_reg == INFLIGHT && retire_hit[gi]) begin
          surf_reg <= calc_surf;
        end
      end
    end
  end

  // Round-robin: scan from rr_ptr, wrapping modulo N (N need not be a
  // power of two, hence the explicit subtract).
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, rr_ptr_reg} + IW'(k);
      if (sum >= IW'(N)) begin
        sum = sum - IW'(N);
      end
      idx = sum[IDW-1:0];
      if (!grant_any && eligible[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

  assign req_ready = grant;

  // Issue register: operands hold their last value between grants.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_reg  <= '0;
      calc_en_reg <= 1'b0;
      calc_a_reg  <= '0;
      calc_b_reg  <= '0;
      calc_id_reg <= '0;
    end else begin
      calc_en_reg <= grant_any;
      if (grant_any) begin
        calc_a_reg  <= a_arr[grant_id];
        calc_b_reg  <= b_arr[grant_id];
        calc_id_reg <= grant_id;
        rr_ptr_reg  <= (grant_id == IDW'(N-1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

  assign calc_en = calc_en_reg;
  assign calc_a  = calc_a_reg;
  assign calc_b  = calc_b_reg;

  // Tag pipe: stage 0 follows calc_en by one cycle so the last stage lines
  // up with the unit's output LAT cycles after calc_en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_v_reg <= '0;
      for (int s = 0; s < LAT; s++) begin
        tag_id_reg[s] <= '0;
      end
    end else begin
      tag_v_reg[0]  <= calc_en_reg;
      tag_id_reg[0] <= calc_id_reg;
      for (int s = 1; s < LAT; s++) begin
        tag_v_reg[s]  <= tag_v_reg[s-1];
        tag_id_reg[s] <= tag_id_reg[s-1];
      end
    end
  end

  // The unit has no reset, so operations issued before reset can still
  // surface for LAT cycles afterwards; the consistency check waits them out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_cnt_reg <= MW'(LAT);
      sync_err_reg <= 1'b0;
    end else if (mask_cnt_reg != '0) begin
      mask_cnt_reg <= mask_cnt_reg - 1'b1;
    end else if (calc_valid != last_v) begin
      sync_err_reg <= 1'b1;
    end
  end

  assign sync_err = sync_err_reg;
  assign busy     = (idle_vec != '1) || (|tag_v_reg);

endmodule

// File: tb/tb_triag_surf_sched.sv
// Directed testbench for triag_surf_sched (N=4, LAT=2).
// Contains a behavioural surface unit (surf = a*b/2, two-cycle latency,
// no reset) with an injectable stray calc_valid pulse.
module tb_triag_surf_sched;

  localparam int N   = 4;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    res_valid;
  logic [32*N-1:0] res_surf;
  logic [N-1:0]    res_ready;
  logic            calc_en;
  logic [15:0]     calc_a;
  logic [15:0]     calc_b;
  logic            calc_valid;
  logic [31:0]     calc_surf;
  logic            busy;
  logic            sync_err;

  logic            inject = 1'b0;
  logic            u_v0 = 1'b0;
  logic            u_v1 = 1'b0;
  logic [31:0]     u_s0 = '0;
  logic [31:0]     u_s1 = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  triag_surf_sched #(.N(N), .LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .res_valid  (res_valid),
    .res_surf   (res_surf),
    .res_ready  (res_ready),
    .calc_en    (calc_en),
    .calc_a     (calc_a),
    .calc_b     (calc_b),
    .calc_valid (calc_valid),
    .calc_surf  (calc_surf),
    .busy       (busy),
    .sync_err   (sync_err)
  );

  // Surface unit model: two pipeline stages, no reset.
  always @(posedge clk) begin
    u_v0 <= calc_en;
    u_s0 <= (32'(calc_a) * 32'(calc_b)) >> 1;
    u_v1 <= u_v0;
    u_s1 <= u_s0;
  end
  assign calc_valid = u_v1 | inject;
  assign calc_surf  = u_s1;

  // One line per completed result transaction.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst_n && res_valid[i] && res_ready[i]) begin
        $display("txn: requester %0d result %0d", i, res_surf[32*i +: 32]);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  logic [3:0] t2_rdy [10] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
  logic [3:0] t2_vld [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1};
  int         surf4  [4]  = '{1000, 4000, 9000, 16000};
  logic [3:0] er;
  logic [3:0] vbits;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_req_ready", req_ready, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_calc_en", calc_en, 0);
    chk("reset_calc_a", calc_a, 0);
    chk("reset_calc_b", calc_b, 0);
    chk("reset_sync_err", sync_err, 0);
    for (int i = 0; i < N; i++) chk("reset_res_surf", res_surf[32*i +: 32], 0);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // All four requesters continuously, results consumed at once
    for (int i = 0; i < N; i++) set_op(i, 16'(1000*(i+1)), 16'(2*(i+1)));
    res_ready = 4'hF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) req_valid = 4'hF;
      #1;
      chk("rr_req_ready", req_ready, t2_rdy[c]);
      chk("rr_res_valid", res_valid, t2_vld[c]);
      vbits = t2_vld[c];
      for (int i = 0; i < N; i++)
        if (vbits[i]) chk("rr_res_surf", res_surf[32*i +: 32], 32'(surf4[i]));
      if (c >= 1 && c <= 4) chk("rr_calc_a", calc_a, 32'(1000*c));
    end
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);
    #1;
    chk("rr_drain_busy", busy, 0);
    chk("rr_drain_res_valid", res_valid, 0);

    // Backpressure: requester 1 holds its result for 20 cycles
    set_op(1, 16'd500, 16'd30);
    res_ready = 4'b1101;
    for (int e = 0; e < 25; e++) begin
      @(negedge clk);
      if (e == 0) req_valid = 4'hF;
      #1;
      if (e < 4) er = 4'(1 << e);
      else if (e == 4) er = 4'h0;
      else begin
        case ((e - 5) % 5)
          0:       er = 4'h1;
          2:       er = 4'h4;
          3:       er = 4'h8;
          default: er = 4'h0;
        endcase
      end
      chk("bp_req_ready", req_ready, er);
      if (e >= 5) begin
        chk("bp_res_valid1", res_valid[1], 1);
        chk("bp_res_surf1", res_surf[63:32], 32'd7500);
      end
    end
    @(negedge clk);
    req_valid = '0;
    res_ready = 4'hF;
    #1;
    chk("bp_hold_last", res_valid[1], 1);
    repeat (6) @(negedge clk);
    #1;
    chk("bp_drain_busy", busy, 0);

    // Single request from requester 2
    set_op(2, 16'd100, 16'd200);
    res_ready = '0;
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    chk("single_req_ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("single_calc_en", calc_en, 1);
    chk("single_calc_a", calc_a, 100);
    chk("single_calc_b", calc_b, 200);
    chk("single_busy", busy, 1);
    chk("single_res_valid_t1", res_valid, 0);
    @(negedge clk);
    #1;
    chk("single_res_valid_t2", res_valid, 0);
    @(negedge clk);
    #1;
    chk("single_res_valid_t3", res_valid, 0);
    @(negedge clk);
    #1;
    chk("single_res_valid_t4", res_valid, 4'b0100);
    chk("single_res_surf_t4", res_surf[95:64], 32'd10000);
    @(negedge clk);
    #1;
    chk("single_res_valid_t5", res_valid, 4'b0100);
    chk("single_res_surf_t5", res_surf[95:64], 32'd10000);
    chk("single_calc_en_idle", calc_en, 0);
    @(negedge clk);
    res_ready = 4'b0100;
    #1;
    chk("single_res_valid_t6", res_valid, 4'b0100);
    @(negedge clk);
    res_ready = '0;
    #1;
    chk("single_consumed", res_valid, 0);
    chk("single_busy_end", busy, 0);

    // Requester 0 alone, leaving the pointer at 1
    set_op(0, 16'd4, 16'd5);
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    chk("r0_req_ready", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("r0_res_valid", res_valid, 4'b0001);
    chk("r0_res_surf", res_surf[31:0], 32'd10);
    res_ready = 4'hF;
    @(negedge clk);
    #1;
    chk("r0_consumed", res_valid, 0);

    // Pointer fairness: 0 and 3 contend with pointer at 1
    set_op(3, 16'd9, 16'd10);
    set_op(0, 16'd6, 16'd6);
    @(negedge clk);
    req_valid = 4'b1001;
    #1;
    chk("fair_first", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("fair_first_calc_a", calc_a, 9);
    repeat (5) @(negedge clk);
    #1;
    chk("fair_first_busy", busy, 0);
    @(negedge clk);
    req_valid = 4'b1001;
    #1;
    chk("fair_second", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("fair_second_calc_a", calc_a, 6);
    repeat (5) @(negedge clk);
    #1;
    chk("fair_second_busy", busy, 0);

    // Reset mid-flight after two issues
    set_op(1, 16'd11, 16'd12);
    set_op(0, 16'd13, 16'd14);
    res_ready = '0;
    @(negedge clk);
    req_valid = 4'b0011;
    #1;
    chk("mid_grant1", req_ready, 4'b0010);
    @(negedge clk);
    #1;
    chk("mid_grant2", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_res_valid", res_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_sync_err", sync_err, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      chk("mid_after_res_valid", res_valid, 0);
      chk("mid_after_busy", busy, 0);
      chk("mid_after_sync_err", sync_err, 0);
    end

    // Stray calc_valid pulse with no tag
    set_op(2, 16'd7, 16'd6);
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    chk("sync_req_ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    inject    = 1'b1;
    #1;
    chk("sync_before", sync_err, 0);
    @(negedge clk);
    inject = 1'b0;
    #1;
    chk("sync_set", sync_err, 1);
    @(negedge clk);
    #1;
    chk("sync_sticky_t3", sync_err, 1);
    @(negedge clk);
    #1;
    chk("sync_res_valid", res_valid, 4'b0100);
    chk("sync_res_surf", res_surf[95:64], 32'd21);
    chk("sync_sticky_t4", sync_err, 1);
    res_ready = 4'hF;
    @(negedge clk);
    #1;
    chk("sync_consumed", res_valid, 0);
    chk("sync_sticky_t5", sync_err, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("sync_cleared", sync_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
